muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit: the execution-side responder for MULT/MULTU/DIV/DIVU requests issued by the controller. It owns the HI/LO special registers. It computes results over 33 clock cycles with a start/busy/done handshake, and exposes HI/LO for MFHI/MFLO. The controller stalls the datapath while busy is high. This replaces the combinational product/quotient path feeding the HI/LO register file.

---
 rtl/muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_unit_iter.sv | 32 +++
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, op codes,
// FSM state encoding and iteration count.
package muldiv_unit_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam int ITER_CNT      = DEFAULT_WIDTH;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction
endpackage

// File: rtl/muldiv_unit_iter.sv
// One combinational step of the unsigned core: radix-2 shift-add multiply
// (mode 0) or restoring divide (mode 1) over a shared 2*WIDTH+1 bit register.
module muldiv_unit_iter #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc_in,
    input  logic [WIDTH-1:0] operand,
    input  logic             mode,
    output logic [2*WIDTH:0] acc_out,
    output logic             q_bit
);
    logic [WIDTH:0]     upper;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     rem_s;
    logic [WIDTH+1:0]   diff;

    always_comb begin
        upper   = acc_in[2*WIDTH:WIDTH];
        sum     = acc_in[0] ? upper + {1'b0, operand} : upper;
        shifted = {acc_in[2*WIDTH-1:0], 1'b0};
        rem_s   = shifted[2*WIDTH:WIDTH];
        diff    = {1'b0, rem_s} - {2'b00, operand};
        q_bit   = 1'b0;
        acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
        if (mode) begin
            // Quotient bit is returned separately; lsb of acc_out is left clear.
            q_bit   = ~diff[WIDTH+1];
            acc_out = {(q_bit ? diff[WIDTH:0] : rem_s), shifted[WIDTH-1:1], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU responder owning HI/LO; unsigned core with
// sign handling at capture and in the final FIX cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           state_dbg
);
    // Handshake: start is taken only in IDLE; busy covers the start edge through
    // the FIX edge; done pulses for the single cycle after HI/LO are written.
    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic [1:0]         op_q;
    logic               sign_a, sign_b, b_zero;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH:0]   iter_acc;
    logic               iter_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_unit_iter #(.WIDTH(WIDTH)) u_iter (
        .acc_in  (acc),
        .operand (opnd),
        .mode    (op_is_div(op_q)),
        .acc_out (iter_acc),
        .q_bit   (iter_q)
    );

    always_comb begin
        mag_a    = (op[0] && a[WIDTH-1]) ? -a : a;
        mag_b    = (op[0] && b[WIDTH-1]) ? -b : b;
        prod_fix = acc[2*WIDTH-1:0];
        quo_fix  = acc[WIDTH-1:0];
        rem_fix  = acc[2*WIDTH-1:WIDTH];
        if (op_q == OP_MULT && (sign_a ^ sign_b)) prod_fix = -acc[2*WIDTH-1:0];
        if (op_q == OP_DIV && (sign_a ^ sign_b))  quo_fix  = -acc[WIDTH-1:0];
        if (op_q == OP_DIV && sign_a)             rem_fix  = -acc[2*WIDTH-1:WIDTH];
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            op_q   <= OP_MULTU;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        count  <= '0;
                        op_q   <= op;
                        a_raw  <= a;
                        sign_a <= op[0] & a[WIDTH-1];
                        sign_b <= op[0] & b[WIDTH-1];
                        b_zero <= op_is_div(op) && (b == '0);
                        dbz    <= 1'b0;
                        // Divide iterates the dividend against the divisor; multiply
                        // shifts the multiplier out of the low half.
                        if (op_is_div(op)) begin
                            acc  <= {{(WIDTH+1){1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{(WIDTH+1){1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end else begin
                        if (we_hi) hi <= wd;
                        if (we_lo) lo <= wd;
                    end
                end
                ST_RUN: begin
                    acc   <= iter_acc | {{(2*WIDTH){1'b0}}, iter_q};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!op_is_div(op_q)) begin
                        {hi, lo} <= prod_fix;
                    end else if (b_zero) begin
                        hi  <= a_raw;
                        lo  <= '1;
                        dbz <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, timing, busy-time side effects,
// MTHI/MTLO and reset behaviour.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wd = '0;
    logic        we_hi = 1'b0, we_lo = 1'b0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;
    state_t      state_dbg;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wd(wd), .busy(busy), .done(done),
        .dbz(dbz), .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Called at a negedge with the unit idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcyc, output bit held);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo; held = 1'b1;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcyc = busy ? 1 : 0;
        if (hi !== h0 || lo !== l0) held = 1'b0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy) bcyc++;
            if (done !== 1'b1 && (hi !== h0 || lo !== l0)) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b done=%b dbz=%b want 000", busy, done, dbz); end
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi, lo); end
        total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, ST_IDLE); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int lat, bc; bit held;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, held);
        total++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin bad++; $display("FAIL multu_res hi=%h lo=%h want fffffffe/00000001", hi, lo); end
        total++; if (lat !== 34) begin bad++; $display("FAIL multu_latency got=%0d want=34", lat); end
        total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d want=33", bc); end
        total++; if (!held) begin bad++; $display("FAIL multu_hold got=changed want=held"); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_width got=%b want=0", done); end
    endtask

    task automatic test_mult();
        int lat, bc; bit held;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bc, held);
        total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_res hi=%h lo=%h want ffffffff/ffffffeb", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat, bc; bit held;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bc, held);
        total++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_res lo=%h hi=%h want fffffffd/ffffffff", lo, hi); end
        @(negedge clk);
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, held);
        total++; if (lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL divu_res lo=%0d hi=%0d want 14/2", lo, hi); end
        total++; if (dbz !== 1'b0) begin bad++; $display("FAIL divu_dbz got=%b want=0", dbz); end
        @(negedge clk);
    endtask

    task automatic test_dbz();
        int lat, bc; bit held;
        run_op(OP_DIVU, 32'h1234, 32'h0, lat, bc, held);
        total++; if (lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin bad++; $display("FAIL dbz_res lo=%h hi=%h want ffffffff/00001234", lo, hi); end
        total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", dbz); end
        total++; if (lat !== 34) begin bad++; $display("FAIL dbz_latency got=%0d want=34", lat); end
        repeat (3) @(negedge clk);
        total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_hold got=%b want=1", dbz); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc, held);
        total++; if (lo !== 32'h80000000 || hi !== 32'h0) begin bad++; $display("FAIL div_ovf_res lo=%h hi=%h want 80000000/0", lo, hi); end
        total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div_ovf_dbz got=%b want=0", dbz); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int lat;
        op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clk);
        lat = 1;
        op = OP_DIVU; a = 32'd9; b = 32'd3; wd = 32'hAA; we_hi = 1'b1; we_lo = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        total++; if (hi !== 32'h0 || lo !== 32'h80000000) begin bad++; $display("FAIL busy_write hi=%h lo=%h want 0/80000000", hi, lo); end
        while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        total++; if (lat !== 34) begin bad++; $display("FAIL busy_start_latency got=%0d want=34", lat); end
        total++; if (hi !== 32'h0 || lo !== 32'd30) begin bad++; $display("FAIL busy_res hi=%h lo=%0d want 0/30", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_mtlo();
        int lat;
        we_lo = 1'b1; wd = 32'h55;
        @(negedge clk);
        we_lo = 1'b0;
        total++; if (lo !== 32'h55 || hi !== 32'h0) begin bad++; $display("FAIL mtlo lo=%h hi=%h want 55/0", lo, hi); end
        we_hi = 1'b1; wd = 32'h12;
        @(negedge clk);
        we_hi = 1'b0;
        total++; if (hi !== 32'h12 || lo !== 32'h55) begin bad++; $display("FAIL mthi hi=%h lo=%h want 12/55", hi, lo); end
        // start and MTLO together: the write must be dropped
        op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1; we_lo = 1'b1; wd = 32'h77;
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0;
        lat = 1;
        total++; if (lo !== 32'h55) begin bad++; $display("FAIL start_wins lo=%h want 55", lo); end
        while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        total++; if (lo !== 32'd6 || hi !== 32'd0) begin bad++; $display("FAIL start_wins_res lo=%0d hi=%0d want 6/0", lo, hi); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit held;
        logic [31:0] e;
        exp_q.push_back(32'd30);
        exp_q.push_back(32'd7);
        run_op(OP_MULTU, 32'd10, 32'd3, lat, bc, held);
        e = exp_q.pop_front();
        total++; if (lo !== e) begin bad++; $display("FAIL b2b_first lo=%0d want=%0d", lo, e); end
        run_op(OP_DIVU, 32'd50, 32'd7, lat, bc, held);
        e = exp_q.pop_front();
        total++; if (lo !== e || hi !== 32'd1) begin bad++; $display("FAIL b2b_second lo=%0d hi=%0d want %0d/1", lo, hi, e); end
        total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", lat); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bc, pulses; bit held;
        op = OP_MULT; a = 32'd5; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL mid_reset busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) pulses++; end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_reset_done got=%0d pulses want=0", pulses); end
        run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, held);
        total++; if (hi !== 32'h0 || lo !== 32'h1 || lat !== 34) begin bad++; $display("FAIL after_reset hi=%h lo=%h lat=%0d want 0/1/34", hi, lo, lat); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_dbz();
        test_ignore_busy();
        test_mtlo();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
